// File: rtl/nemu_packet_sink_pkg.sv
// Shared NEMU definitions: packet format, port count, sink state encoding
// and small helpers used by the packet sink and the statistics collector.
package nemu_packet_sink_pkg;

  localparam int PORTS = 16;

  // Ceiling log2 for elaboration-time widths; log2(1) = 0.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int PORT_W = log2(PORTS);
  localparam int HIST_BINS_DEFAULT = 8;

  // data carries the injection timestamp written by the source.
  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] dest;
    logic [31:0]       data;
  } packet_t;

  typedef enum logic [1:0] {
    SINK_WARMUP  = 2'd0,
    SINK_MEASURE = 2'd1,
    SINK_DONE    = 2'd2
  } sink_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/nemu_latency_binner.sv
// Combinational leading-one encoder: latency -> log2 histogram bin, with
// everything at or above 2^(HIST_BINS-1) folded into the last bin.
module nemu_latency_binner
  import nemu_packet_sink_pkg::*;
#(
  parameter int HIST_BINS = HIST_BINS_DEFAULT,
  localparam int BIN_W = $clog2(HIST_BINS)
) (
  input  logic [31:0]      latency,
  output logic [BIN_W-1:0] bin
);

  logic [5:0] msb;

  // Latencies 0 and 1 both leave msb at 0, so bin 0 covers 0-1.
  always_comb begin
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (latency[i]) msb = 6'(i);
    end
    if (msb >= 6'(HIST_BINS - 1)) bin = BIN_W'(HIST_BINS - 1);
    else                          bin = BIN_W'(msb);
  end

endmodule

// File: rtl/nemu_packet_sink.sv
// Per-core packet sink: latency measurement, routing check and windowed
// latency statistics (count, sum, min, max, log2 histogram).
module nemu_packet_sink
  import nemu_packet_sink_pkg::*;
#(
  parameter int PORT_NO   = 0,
  parameter int WARMUP    = 600,
  parameter int MEASURE   = 10000,
  parameter int HIST_BINS = HIST_BINS_DEFAULT
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic [31:0] i_timestamp,
  input  packet_t     i_pkt_in,
  output sink_state_e o_state,
  output logic        o_done,
  output logic [31:0] o_total_count,
  output logic [31:0] o_rx_count,
  output logic [47:0] o_lat_sum,
  output logic [31:0] o_lat_min,
  output logic [31:0] o_lat_max,
  output logic [31:0] o_hist [HIST_BINS],
  output logic        o_dest_error
);

  localparam int BIN_W = $clog2(HIST_BINS);

  logic [31:0]      cycle_cnt;
  logic             dest_ok;
  logic             s1_valid;
  logic             s1_misroute;
  logic             s1_incl;
  logic [31:0]      s1_lat;
  logic [BIN_W-1:0] s1_bin;
  logic             s2_take;
  logic [48:0]      sum_next;

  // Window state machine; reset_n is active high despite its name.
  always_ff @(posedge i_clk) begin
    if (reset_n) begin
      o_state   <= SINK_WARMUP;
      o_done    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      case (o_state)
        SINK_WARMUP: begin
          if (cycle_cnt == 32'(WARMUP - 1)) begin
            o_state   <= SINK_MEASURE;
            cycle_cnt <= '0;
          end
        end
        SINK_MEASURE: begin
          if (cycle_cnt == 32'(MEASURE - 1)) begin
            o_state   <= SINK_DONE;
            o_done    <= 1'b1;
            cycle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dest_ok = (i_pkt_in.dest == PORT_W'(PORT_NO));

  // S1: the include tag is frozen here so a packet arriving in the last
  // MEASURE cycle still counts after the state has moved to DONE.
  always_ff @(posedge i_clk) begin
    if (reset_n) begin
      s1_valid    <= 1'b0;
      s1_misroute <= 1'b0;
      s1_incl     <= 1'b0;
      s1_lat      <= '0;
    end else begin
      s1_valid    <= i_pkt_in.valid && dest_ok;
      s1_misroute <= i_pkt_in.valid && !dest_ok;
      s1_incl     <= (o_state == SINK_MEASURE);
      s1_lat      <= i_timestamp - i_pkt_in.data;
    end
  end

  nemu_latency_binner #(
    .HIST_BINS (HIST_BINS)
  ) u_binner (
    .latency (s1_lat),
    .bin     (s1_bin)
  );

  always_comb begin
    s2_take  = s1_valid && s1_incl;
    sum_next = {1'b0, o_lat_sum} + 49'(s1_lat);
  end

  // S2: every accumulator updates in one cycle, so back-to-back packets
  // never collide on a read-modify-write.
  always_ff @(posedge i_clk) begin
    if (reset_n) begin
      o_total_count <= '0;
      o_rx_count    <= '0;
      o_lat_sum     <= '0;
      o_lat_min     <= 32'hFFFF_FFFF;
      o_lat_max     <= '0;
      o_dest_error  <= 1'b0;
      for (int b = 0; b < HIST_BINS; b++) o_hist[b] <= '0;
    end else begin
      if (s1_misroute) o_dest_error <= 1'b1;
      if (s1_valid) o_total_count <= sat_inc32(o_total_count);
      if (s2_take) begin
        o_rx_count <= sat_inc32(o_rx_count);
        o_lat_sum  <= sum_next[48] ? 48'hFFFF_FFFF_FFFF : sum_next[47:0];
        if (s1_lat <= o_lat_min) o_lat_min <= s1_lat;
        if (s1_lat >= o_lat_max) o_lat_max <= s1_lat;
      end
      for (int b = 0; b < HIST_BINS; b++) begin
        if (s2_take && s1_bin == BIN_W'(b)) o_hist[b] <= sat_inc32(o_hist[b]);
      end
    end
  end

endmodule

// File: doc/nemu_packet_sink.md
# nemu_packet_sink

Per-core packet sink: consumes the `packet_t` stream the network delivers to one core, the return side of the per-core packet source. It computes per-packet network latency from the embedded injection timestamp and checks routing correctness. Over a warm-up / measure / done window it accumulates count, sum, min, max and a log2 latency histogram. One instance per core; the outputs feed the NEMU statistics collector and testbench reporting.

## Interface
Parameters:
- `PORT_NO`, 0: core index of this sink; the expected `dest` of every arriving packet.
- `WARMUP`, 600: cycles after reset before measurement starts; must be ≥1.
- `MEASURE`, 10000: length of the measurement window in cycles; must be ≥1.
- `HIST_BINS`, 8: number of log2 latency histogram bins; must be ≥2.

Ports:
- `i_clk`, in, 1: single clock; all logic is on its rising edge.
- `reset_n`, in, 1: synchronous, active-high reset. The historical name is kept; polarity is high.
- `i_timestamp`, in, 32: global cycle counter, the same one the sources use.
- `i_pkt_in`, in, `packet_t`: arriving packet, accepted whenever `.valid`=1. There is no backpressure; the sink accepts every cycle.
- `o_state`, out, 2: `sink_state_e` (WARMUP=0, MEASURE=1, DONE=2).
- `o_done`, out, 1: high while in DONE.
- `o_total_count`, out, 32: all correctly routed packets received since reset.
- `o_rx_count`, out, 32: packets included in the statistics.
- `o_lat_sum`, out, 48: sum of the included latencies.
- `o_lat_min`, out, 32: minimum included latency.
- `o_lat_max`, out, 32: maximum included latency.
- `o_hist`, out, `[HIST_BINS][32]`: histogram bin counts.
- `o_dest_error`, out, 1: sticky misroute flag.

## Operation
- Reset values:
  - state WARMUP; cycle counter 0.
  - All counts, `o_lat_sum`, `o_lat_max` and `o_hist` are 0.
  - `o_lat_min` = 32'hFFFF_FFFF.
  - `o_dest_error` = 0; `o_done` = 0.
- State machine, driven by a 32-bit cycle counter that increments every cycle and clears on each state change:
  - WARMUP → MEASURE when counter == WARMUP-1.
  - MEASURE → DONE when counter == MEASURE-1.
  - DONE is terminal until reset.
- Latency = `i_timestamp - i_pkt_in.data`, computed as unsigned modulo 2^32, so timestamp wrap-around gives the correct small value.
- A misrouted packet has valid=1 and `dest != PORT_NO`. It sets `o_dest_error` (sticky) and is excluded from every count and statistic.
- A correctly routed packet always increments `o_total_count`. It is included in the statistics only if the state was MEASURE in its arrival cycle. The include tag is captured at arrival, so a packet arriving in the last MEASURE cycle counts even though the accumulators update after the state has entered DONE.
- Histogram binning:
  - Bin 0 holds latency 0–1.
  - Bin k holds [2^k, 2^(k+1)) for 1 ≤ k ≤ HIST_BINS-2.
  - Bin HIST_BINS-1 holds everything ≥ 2^(HIST_BINS-1).
- Saturation: every 32-bit count and bin saturates at all-ones, and `o_lat_sum` saturates at 2^48-1. None of them wrap.
- Min and max updates use ≤ and ≥ comparisons against the current value. The first included packet therefore sets both.

## Timing
- Two-stage pipeline:
  - S1 registers latency, include tag, misroute flag and valid.
  - S2 updates the accumulators and bins.
- Latency from packet arrival to visible outputs is 2 cycles: packet at edge N gives counts, statistics and `o_dest_error` valid after edge N+2.
- Throughput is one packet per cycle. Back-to-back packets each update in consecutive cycles, with no loss and no read-modify-write hazard, because all S2 state is updated in a single cycle.
- `o_state` and `o_done` are registered:
  - MEASURE is visible from cycle WARMUP after reset release.
  - DONE is visible from cycle WARMUP+MEASURE.
- Reset asserted mid-operation clears both pipeline stages. Packets in flight are dropped and not counted.

## Structure
- Add `sink_state_e` and `HIST_BINS_DEFAULT` to the shared `config.sv` alongside `packet_t`, `PORTS` and `log2`.
- One sub-module, `nemu_latency_binner`: a combinational leading-one encoder that maps a 32-bit latency to a `$clog2(HIST_BINS)`-bit bin index, with saturation into the last bin. It is reused by the network-level statistics collector.
- Accumulators and the state machine live in `nemu_packet_sink`.

## Test plan
- **Warm-up exclusion.** Send a packet (dest=`PORT_NO`, data=100) at timestamp 110 during WARMUP. Required: `o_total_count`=1, `o_rx_count`=0, `o_lat_min`=FFFF_FFFF, all bins 0.
- **Measurement statistics.** In MEASURE, send packets with latencies 1, 5, 300 on three consecutive cycles. Required, two cycles after the last: `o_rx_count`=3, `o_lat_sum`=306, `o_lat_min`=1, `o_lat_max`=300, bins 0/2/8 each = 1 (or the last bin, 7, for 300 when `HIST_BINS`=8).
- **Timestamp wrap.** Send data=32'hFFFF_FFFE, `i_timestamp`=3. Required: latency 5, `o_lat_max`=5.
- **Misroute.** Send dest=`PORT_NO`+1 with valid. Required: `o_dest_error`=1 after 2 cycles and held, all counts unchanged; a later valid packet is still counted normally.
- **Window edge.** With `WARMUP`=4 and `MEASURE`=8, send packets in the last MEASURE cycle and in the first DONE cycle. Required: only the first is in `o_rx_count`, both are in `o_total_count`, and `o_done`=1 from cycle 12.
- **Reset mid-stream.** Assert `reset_n` one cycle after a valid packet. Required: all outputs return to their reset values and the in-flight packet is never counted.
